// File: rtl/uart_boot_loader.sv
// Serial boot loader: takes a length-prefixed byte image from the UART receiver, writes it to RAM
// over APB, and releases the core from reset once the trailing checksum byte matches.
module uart_boot_loader #(
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
    parameter logic [31:0] MAX_LEN   = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        psel,
    output logic        penable,
    input  logic        pready,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pwstrb,
    input  logic [31:0] prdata,
    input  logic        pslverr,
    output logic        core_rst_n,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_SETUP, S_ACCESS, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t      state_q;
    logic [31:0] len_q;
    logic [31:0] byte_cnt_q;
    logic [31:0] wbuf_q;
    logic [3:0]  strb_q;
    logic [1:0]  hdr_cnt_q;
    logic [1:0]  lane_q;
    logic [29:0] widx_q;
    logic [7:0]  csum_q;

    logic        psel_q;
    logic        penable_q;
    logic        rx_ready_q;
    logic        core_rst_n_q;
    logic        done_q;
    logic        error_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pwstrb_q;

    logic        accept;
    logic [31:0] len_d;
    logic [31:0] wbuf_d;
    logic [3:0]  strb_d;
    logic [31:0] byte_cnt_d;
    logic        unused_prdata;

    assign accept        = rx_valid && rx_ready_q;
    assign unused_prdata = ^prdata;

    // Buffer/length values as they look once the byte on rx_data is absorbed.
    always_comb begin
        len_d                         = {rx_data, len_q[31:8]};
        wbuf_d                        = wbuf_q;
        wbuf_d[{lane_q, 3'b000} +: 8] = rx_data;
        strb_d                        = strb_q | (4'b0001 << lane_q);
        byte_cnt_d                    = byte_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HDR;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            wbuf_q       <= '0;
            strb_q       <= '0;
            hdr_cnt_q    <= '0;
            lane_q       <= '0;
            widx_q       <= '0;
            csum_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rx_ready_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwstrb_q     <= '0;
        end else begin
            case (state_q)
                S_HDR: begin
                    rx_ready_q <= 1'b1;
                    if (accept) begin
                        len_q     <= len_d;
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == 2'd3) begin
                            if (len_d > MAX_LEN) begin
                                state_q <= S_ERROR;
                                error_q <= 1'b1;
                            end else if (len_d == 32'd0) begin
                                state_q <= S_CSUM;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        wbuf_q     <= wbuf_d;
                        strb_q     <= strb_d;
                        lane_q     <= lane_q + 2'd1;
                        byte_cnt_q <= byte_cnt_d;
                        csum_q     <= csum_q + rx_data;
                        if (lane_q == 2'd3 || byte_cnt_d == len_q) begin
                            state_q    <= S_SETUP;
                            rx_ready_q <= 1'b0;
                            psel_q     <= 1'b1;
                            paddr_q    <= LOAD_BASE + {widx_q, 2'b00};
                            pwdata_q   <= wbuf_d;
                            pwstrb_q   <= strb_d;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        rx_ready_q <= 1'b1;
                        if (pslverr) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            widx_q  <= widx_q + 30'd1;
                            wbuf_q  <= '0;
                            strb_q  <= '0;
                            lane_q  <= '0;
                            state_q <= (byte_cnt_q == len_q) ? S_CSUM : S_DATA;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                            rx_ready_q   <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    rx_ready_q <= 1'b0;
                end
                S_ERROR: begin
                    // Keep draining so the upstream FIFO never backs up after a failure.
                    rx_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_HDR;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign paddr      = paddr_q;
    assign pwrite     = 1'b1;
    assign pwdata     = pwdata_q;
    assign pwstrb     = pwstrb_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed and random frames checked against a word-chunking
// reference model, plus an APB responder that watches transfer protocol.
module tb_uart_boot_loader;

    localparam logic [31:0] BASE = 32'h2000_0100;
    localparam logic [31:0] MAXL = 32'd64;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        psel;
    logic        penable;
    logic        pready = 1'b0;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic [31:0] prdata = 32'h0;
    logic        pslverr = 1'b0;
    logic        core_rst_n;
    logic        done;
    logic        error;

    uart_boot_loader #(.LOAD_BASE(BASE), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .psel(psel), .penable(penable), .pready(pready), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata), .pslverr(pslverr),
        .core_rst_n(core_rst_n), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int proto_bad = 0;
    int waits_cfg = 0;
    int err_idx = -1;
    int wcnt = 0;
    int wnum = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_s[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_s[$];
    bit          exp_done;
    bit          exp_err;

    logic [31:0] s_a = '0;
    logic [31:0] s_d = '0;
    logic [3:0]  s_s = '0;
    bit          prev_psel = 1'b0;
    bit          prev_cmpl = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // APB responder and protocol watcher, evaluated away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (psel && rx_ready) proto_bad++;
                if (done && error) proto_bad++;
                if (core_rst_n !== done) proto_bad++;
                if (pwrite !== 1'b1) proto_bad++;
                if (penable && !psel) proto_bad++;
                if (psel && paddr[1:0] != 2'b00) proto_bad++;
            end
            if (psel && penable) begin
                if (!prev_psel) proto_bad++;
                if (paddr !== s_a || pwdata !== s_d || pwstrb !== s_s) proto_bad++;
                if (wcnt < waits_cfg) begin
                    pready  = 1'b0;
                    pslverr = 1'b0;
                    wcnt++;
                end else begin
                    pready  = 1'b1;
                    pslverr = (wnum == err_idx);
                    got_a.push_back(paddr);
                    got_d.push_back(pwdata);
                    got_s.push_back(pwstrb);
                    wnum++;
                    wcnt = 0;
                end
            end else begin
                if (psel) begin
                    if (prev_cmpl) proto_bad++;
                    s_a = paddr;
                    s_d = pwdata;
                    s_s = pwstrb;
                end
                pready  = 1'b0;
                pslverr = 1'b0;
                wcnt    = 0;
            end
            prev_cmpl = psel && penable && pready;
            prev_psel = psel;
        end
    end

    // Reference: chop the payload into 4-byte words, decide the outcome from the frame rules.
    task automatic model(input int L, input bq_t pl, input logic [7:0] cs, input int eidx);
        int sum;
        int nw;
        logic [31:0] d;
        logic [3:0]  s;
        exp_a.delete();
        exp_d.delete();
        exp_s.delete();
        if (L > int'(MAXL)) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        nw = (L + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = 32'h0;
            s = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < L) begin
                    d = d | (32'(pl[4 * w + j]) << (8 * j));
                    s = s | (4'(1) << j);
                end
            end
            exp_a.push_back(BASE + 32'(4 * w));
            exp_d.push_back(d);
            exp_s.push_back(s);
        end
        if (eidx >= 0 && eidx < nw) begin
            while (exp_a.size() > eidx + 1) begin
                void'(exp_a.pop_back());
                void'(exp_d.pop_back());
                void'(exp_s.pop_back());
            end
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        sum = 0;
        for (int i = 0; i < L; i++) sum = (sum + int'(pl[i])) % 256;
        exp_done = (int'(cs) == sum);
        exp_err  = !exp_done;
    endtask

    task automatic feed(input bq_t q, input bit hold, output bit ok);
        int n;
        ok = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            if (!hold && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = q[i];
            n = 0;
            while (!rx_ready && ok) begin
                @(negedge clk);
                n++;
                if (n > 200) ok = 1'b0;
            end
            if (!ok) break;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({name, " rst apb"}, {psel, penable, pwrite, pwstrb}, {1'b0, 1'b0, 1'b1, 4'h0});
        check({name, " rst paddr"}, paddr, 32'h0);
        check({name, " rst pwdata"}, pwdata, 32'h0);
        check({name, " rst status"}, {rx_ready, core_rst_n, done, error}, 4'b0000);
        rst = 1'b0;
    endtask

    task automatic run_case(input string name, input int L, input bq_t pl, input logic [7:0] cs,
                            input int waits, input int eidx, input bit hold, input bit do_rst);
        bq_t fr;
        logic [31:0] lw;
        bit ok;
        int n;
        lw = 32'(L);
        for (int i = 0; i < 4; i++) fr.push_back(lw[8 * i +: 8]);
        if (L > int'(MAXL)) begin
            for (int i = 0; i < 5; i++) fr.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < L; i++) fr.push_back(pl[i]);
            fr.push_back(cs);
        end
        model(L, pl, cs, eidx);
        if (do_rst) do_reset(name);
        got_a.delete();
        got_d.delete();
        got_s.delete();
        wnum      = 0;
        waits_cfg = waits;
        err_idx   = eidx;
        proto_bad = 0;
        feed(fr, hold, ok);
        check({name, " all bytes taken"}, 32'(ok), 32'd1);
        n = 0;
        while (!(done || error) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, " nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < got_a.size()) begin
                check({name, " paddr"}, got_a[i], exp_a[i]);
                check({name, " pwdata"}, got_d[i], exp_d[i]);
                check({name, " pwstrb"}, 32'(got_s[i]), 32'(exp_s[i]));
            end
        end
        check({name, " done/error"}, {30'h0, done, error}, {30'h0, exp_done, exp_err});
        check({name, " core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
        check({name, " protocol"}, 32'(proto_bad), 32'd0);
    endtask

    initial begin
        bq_t t1;
        bq_t t2;
        bq_t pl;
        bq_t fr;
        bit ok;
        bit seen;
        int n;
        int L;
        logic [7:0] cs;

        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        t2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        run_case("t1_basic", 4, t1, 8'hAA, 0, -1, 1'b0, 1'b1);
        check("t1 word", got_d.size() > 0 ? got_d[0] : 32'hDEAD_BEEF, 32'h4433_2211);
        run_case("t2_tail", 6, t2, 8'h15, 0, -1, 1'b0, 1'b1);
        check("t2 tail word", got_d.size() > 1 ? {got_d[1][27:0], got_s[1]} : 32'hDEAD_BEEF,
              {28'h000_0605, 4'h3});
        run_case("t3_stall", 4, t1, 8'hAA, 3, -1, 1'b1, 1'b1);
        pl.delete();
        run_case("t4_toolong", int'(MAXL) + 1, pl, 8'h00, 0, -1, 1'b0, 1'b1);
        run_case("t5_badsum", 4, t1, 8'h00, 0, -1, 1'b0, 1'b1);

        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_case("t6_slverr", 8, pl, 8'h00, 1, 0, 1'b0, 1'b1);

        // Reset while the first word of the 6-byte image is stuck in ACCESS.
        do_reset("t6_rstmid");
        waits_cfg = 5;
        err_idx   = -1;
        fr = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        feed(fr, 1'b1, ok);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            if (psel && penable) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("t6 rstmid reached access", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rstmid abandon", {29'h0, psel, penable, core_rst_n}, 32'h0);
        rst = 1'b0;
        run_case("t6_rerun", 6, t2, 8'h15, 0, -1, 1'b0, 1'b0);

        pl.delete();
        run_case("len0_ok", 0, pl, 8'h00, 0, -1, 1'b0, 1'b1);
        run_case("len0_bad", 0, pl, 8'h01, 0, -1, 1'b0, 1'b1);

        pl.delete();
        cs = 8'h00;
        for (int i = 0; i < int'(MAXL); i++) begin
            pl.push_back(8'($urandom));
            cs = cs + pl[i];
        end
        run_case("len_max", int'(MAXL), pl, cs, 1, -1, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            L = $urandom_range(1, int'(MAXL));
            pl.delete();
            cs = 8'h00;
            for (int i = 0; i < L; i++) begin
                pl.push_back(8'($urandom));
                cs = cs + pl[i];
            end
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            run_case("random", L, pl, cs, $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
